// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 input padding/absorb stage.
package sha3_pkg;

    typedef logic [63:0] lane_t;
    typedef logic [0:4][0:4][63:0] state_t;

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        PADBLK
    } fsm_t;

    localparam logic [7:0] SHA3_SUFFIX  = 8'h06;
    localparam logic [7:0] SHAKE_SUFFIX = 8'h1F;
    localparam logic [7:0] PAD_END      = 8'h80;

    localparam int RATE_224 = 18;
    localparam int RATE_256 = 17;
    localparam int RATE_384 = 13;
    localparam int RATE_512 = 9;

endpackage

// File: rtl/sha3_lane_mask.sv
// Keeps the low n bytes of a lane, zeroes the rest, and optionally drops the
// domain suffix into byte n. With n >= 8 the whole lane passes and no suffix fits.
module sha3_lane_mask
    import sha3_pkg::*;
#(
    parameter logic [7:0] DSUFFIX = SHA3_SUFFIX
) (
    input  lane_t      word,
    input  logic [3:0] n,
    input  logic       ins,
    output lane_t      masked
);

    // Per-byte select: message byte below n, suffix at n, zero above.
    always_comb begin
        masked = '0;
        for (int b = 0; b < 8; b++) begin
            if (b < int'(n)) begin
                masked[8*b +: 8] = word[8*b +: 8];
            end else if ((b == int'(n)) && ins) begin
                masked[8*b +: 8] = DSUFFIX;
            end
        end
    end

endmodule

// File: rtl/sha3_pad_absorb.sv
// Packs 64-bit message words into rate blocks, applies SHA-3 multi-rate
// padding and hands complete 1600-bit blocks to the permutation core.
//
// state  | meaning
// FILL   | accepting message words into the rate buffer
// EMIT   | block presented to the core, held until blk_ready
// PADBLK | building the extra block when the suffix did not fit
module sha3_pad_absorb
    import sha3_pkg::*;
#(
    parameter int         WIDTH      = 64,
    parameter int         RATE_LANES = RATE_256,
    parameter logic [7:0] DSUFFIX    = SHA3_SUFFIX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] msg_data,
    input  logic             msg_valid,
    input  logic             msg_last,
    input  logic [3:0]       msg_bytes,
    output logic             msg_ready,
    output state_t           blk_data,
    output logic             blk_valid,
    output logic             blk_last,
    input  logic             blk_ready,
    output logic             busy
);

    localparam int CNT_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATE_LANES - 1);

    fsm_t             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             pad_q, pad_d;
    logic             busy_q, busy_d;
    logic             armed_q;
    lane_t            lanes_q [RATE_LANES];
    lane_t            lanes_d [RATE_LANES];

    lane_t            mask_word, masked;
    logic [3:0]       mask_n;
    logic             mask_ins;

    // PADBLK only needs the suffix at byte 0 of an empty lane.
    always_comb begin
        mask_word = (state_q == PADBLK) ? '0 : msg_data;
        mask_n    = (state_q == PADBLK) ? 4'd0 : (msg_last ? msg_bytes : 4'd8);
        mask_ins  = (state_q == PADBLK) || msg_last;
    end

    sha3_lane_mask #(.DSUFFIX(DSUFFIX)) u_mask (
        .word   (mask_word),
        .n      (mask_n),
        .ins    (mask_ins),
        .masked (masked)
    );

    // State and datapath registers; armed_q keeps msg_ready low through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            pad_q   <= 1'b0;
            busy_q  <= 1'b0;
            armed_q <= 1'b0;
            for (int k = 0; k < RATE_LANES; k++) lanes_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
            busy_q  <= busy_d;
            armed_q <= 1'b1;
            lanes_q <= lanes_d;
        end
    end

    // Next-state, buffer update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        pad_d     = pad_q;
        busy_d    = busy_q;
        lanes_d   = lanes_q;
        msg_ready = 1'b0;
        blk_valid = 1'b0;

        case (state_q)
            FILL: begin
                msg_ready = armed_q;
                if (msg_valid && armed_q) begin
                    busy_d = 1'b1;
                    for (int k = 0; k < RATE_LANES; k++) begin
                        if (k == int'(cnt_q)) lanes_d[k] = masked;
                    end
                    if (!msg_last) begin
                        if (cnt_q == CNT_MAX) begin
                            state_d = EMIT;
                            last_d  = 1'b0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if ((msg_bytes >= 4'd8) && (cnt_q == CNT_MAX)) begin
                        // Full final word closes the block; suffix goes to a new one.
                        state_d = EMIT;
                        last_d  = 1'b0;
                        pad_d   = 1'b1;
                    end else begin
                        if (msg_bytes >= 4'd8) begin
                            for (int k = 0; k < RATE_LANES; k++) begin
                                if (k == int'(cnt_q) + 1) lanes_d[k][7:0] = lanes_d[k][7:0] ^ DSUFFIX;
                            end
                        end
                        // XOR so the end marker merges with a suffix in the same byte.
                        lanes_d[RATE_LANES-1][63:56] = lanes_d[RATE_LANES-1][63:56] ^ PAD_END;
                        state_d = EMIT;
                        last_d  = 1'b1;
                    end
                end
            end
            EMIT: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    for (int k = 0; k < RATE_LANES; k++) lanes_d[k] = '0;
                    cnt_d = '0;
                    if (pad_q) begin
                        state_d = PADBLK;
                    end else begin
                        state_d = FILL;
                        if (last_q) busy_d = 1'b0;
                    end
                end
            end
            PADBLK: begin
                lanes_d[0] = masked;
                lanes_d[RATE_LANES-1][63:56] = lanes_d[RATE_LANES-1][63:56] ^ PAD_END;
                pad_d   = 1'b0;
                last_d  = 1'b1;
                state_d = EMIT;
            end
            default: state_d = FILL;
        endcase
    end

    // Map rate lanes onto the core's [x][y] layout; capacity lanes stay zero.
    always_comb begin
        blk_data = '0;
        for (int k = 0; k < RATE_LANES; k++) blk_data[k % 5][k / 5] = lanes_q[k];
        blk_last = (state_q == EMIT) && last_q;
        busy     = busy_q;
    end

endmodule
